// File: rtl/pc_pkg.sv
// Shared action codes for the PC unit next-PC priority encoder.
// The bench uses the same codes.
package pc_pkg;

  localparam int ACT_W = 3;

  localparam logic [ACT_W-1:0] ACT_HOLD = 3'd0;
  localparam logic [ACT_W-1:0] ACT_RET  = 3'd1;
  localparam logic [ACT_W-1:0] ACT_CALL = 3'd2;
  localparam logic [ACT_W-1:0] ACT_JMP  = 3'd3;
  localparam logic [ACT_W-1:0] ACT_BR   = 3'd4;
  localparam logic [ACT_W-1:0] ACT_SEQ  = 3'd5;

endpackage

// File: rtl/pc_ras.sv
// Circular return-address stack.
// When the stack is full, a push overwrites the oldest entry. A pop on an empty stack has no effect.
module pc_ras #(
  parameter int WIDTH     = 16,
  parameter int RAS_DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             empty,
  output logic             full,
  output logic             err
);

  localparam int PW = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
  localparam int CW = $clog2(RAS_DEPTH + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(RAS_DEPTH);

  logic [WIDTH-1:0] mem [RAS_DEPTH];
  logic [PW-1:0]    ptr;
  logic [PW-1:0]    ptr_nxt;
  logic [CW-1:0]    cnt;
  logic [CW-1:0]    cnt_nxt;

  assign dout = mem[ptr];
  assign err  = (push && full) || (pop && empty);

  always_comb begin
    ptr_nxt = ptr;
    cnt_nxt = cnt;
    if (pop) begin
      if (!empty) begin
        ptr_nxt = ptr - PW'(1);
        cnt_nxt = cnt - CW'(1);
      end
    end else if (push) begin
      ptr_nxt = ptr + PW'(1);
      if (!full)
        cnt_nxt = cnt + CW'(1);
    end
  end

  // Only the control state is reset; the entries become stale once the count is zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr   <= '0;
      cnt   <= '0;
      empty <= 1'b1;
      full  <= 1'b0;
    end else begin
      ptr   <= ptr_nxt;
      cnt   <= cnt_nxt;
      empty <= (cnt_nxt == '0);
      full  <= (cnt_nxt == CNT_MAX);
    end
  end

  always_ff @(posedge clk) begin
    if (push && !pop)
      mem[ptr_nxt] <= din;
  end

endmodule

// File: rtl/pc_stack_unit.sv
// Program-counter unit with a next-PC priority mux and a return-address stack.
// The priority order is ret > call > jmp > branch > sequential, and stall holds all state.
module pc_stack_unit
  import pc_pkg::*;
#(
  parameter int              WIDTH     = 16,
  parameter int              STEP      = 1,
  parameter logic [WIDTH-1:0] RESET_VEC = '0,
  parameter int              RAS_DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    stall,
  input  logic                    br_take,
  input  logic signed [WIDTH-1:0] br_off,
  input  logic                    jmp,
  input  logic [WIDTH-1:0]        jmp_tgt,
  input  logic                    call,
  input  logic                    ret,
  output logic [WIDTH-1:0]        pc,
  output logic                    ras_empty,
  output logic                    ras_full,
  output logic                    ras_err
);

  localparam logic [WIDTH-1:0] STEP_W = WIDTH'(STEP);

  logic [ACT_W-1:0] act;
  logic [WIDTH-1:0] pc_seq;
  logic [WIDTH-1:0] pc_nxt;
  logic [WIDTH-1:0] ras_top;
  logic             ras_push;
  logic             ras_pop;
  logic             ras_err_pulse;

  // The sum is taken modulo 2^WIDTH, and any overflow is dropped.
  function automatic logic [WIDTH-1:0] pc_add(input logic [WIDTH-1:0] a,
                                              input logic [WIDTH-1:0] b);
    logic [WIDTH:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[WIDTH-1:0];
  endfunction

  assign pc_seq = pc_add(pc, STEP_W);

  always_comb begin
    act = ACT_SEQ;
    if (stall)        act = ACT_HOLD;
    else if (ret)     act = ACT_RET;
    else if (call)    act = ACT_CALL;
    else if (jmp)     act = ACT_JMP;
    else if (br_take) act = ACT_BR;
  end

  always_comb begin
    pc_nxt = pc_seq;
    unique case (act)
      ACT_HOLD: pc_nxt = pc;
      ACT_RET:  pc_nxt = ras_empty ? pc_seq : ras_top;
      ACT_CALL: pc_nxt = jmp_tgt;
      ACT_JMP:  pc_nxt = jmp_tgt;
      ACT_BR:   pc_nxt = pc_add(pc, br_off);
      default:  pc_nxt = pc_seq;
    endcase
  end

  assign ras_push = (act == ACT_CALL);
  assign ras_pop  = (act == ACT_RET);

  pc_ras #(
    .WIDTH     (WIDTH),
    .RAS_DEPTH (RAS_DEPTH)
  ) u_ras (
    .clk   (clk),
    .rst   (rst),
    .push  (ras_push),
    .pop   (ras_pop),
    .din   (pc_seq),
    .dout  (ras_top),
    .empty (ras_empty),
    .full  (ras_full),
    .err   (ras_err_pulse)
  );

  // PC register and sticky stack error
  always_ff @(posedge clk) begin
    if (rst) begin
      pc      <= RESET_VEC;
      ras_err <= 1'b0;
    end else begin
      pc <= pc_nxt;
      if (ras_err_pulse)
        ras_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_pc_stack_unit.sv
// Directed bench for pc_stack_unit (WIDTH=16, STEP=1, RESET_VEC=0, RAS_DEPTH=4).
// Expected values are computed by hand from the intended behaviour.
module tb_pc_stack_unit;
  import pc_pkg::*;

  logic               clk = 1'b0;
  logic               rst;
  logic               stall;
  logic               br_take;
  logic signed [15:0] br_off;
  logic               jmp;
  logic [15:0]        jmp_tgt;
  logic               call;
  logic               ret;
  logic [15:0]        pc;
  logic               ras_empty;
  logic               ras_full;
  logic               ras_err;

  int n_chk  = 0;
  int n_fail = 0;

  pc_stack_unit #(
    .WIDTH     (16),
    .STEP      (1),
    .RESET_VEC (16'h0000),
    .RAS_DEPTH (4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .stall     (stall),
    .br_take   (br_take),
    .br_off    (br_off),
    .jmp       (jmp),
    .jmp_tgt   (jmp_tgt),
    .call      (call),
    .ret       (ret),
    .pc        (pc),
    .ras_empty (ras_empty),
    .ras_full  (ras_full),
    .ras_err   (ras_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    rst = 1'b0; stall = 1'b0; br_take = 1'b0; br_off = '0;
    jmp = 1'b0; jmp_tgt = '0; call = 1'b0; ret = 1'b0;
  endtask

  // Drive one cycle of controls and sample 1 time unit after the active edge.
  task automatic cyc(input logic r, input logic s, input logic b, input logic [15:0] off,
                     input logic j, input logic [15:0] tgt, input logic c, input logic rt);
    rst = r; stall = s; br_take = b; br_off = off; jmp = j; jmp_tgt = tgt; call = c; ret = rt;
    @(posedge clk);
    #1;
    idle_inputs();
  endtask

  task automatic seq_cyc();             cyc(0, 0, 0, 16'h0, 0, 16'h0, 0, 0); endtask
  task automatic jmp_cyc(input logic [15:0] t);  cyc(0, 0, 0, 16'h0, 1, t, 0, 0); endtask
  task automatic call_cyc(input logic [15:0] t); cyc(0, 0, 0, 16'h0, 0, t, 1, 0); endtask
  task automatic ret_cyc();             cyc(0, 0, 0, 16'h0, 0, 16'h0, 0, 1); endtask

  logic [15:0] exp_ret [4] = '{16'h4001, 16'h3001, 16'h2001, 16'h1001};
  logic [15:0] tgts    [5] = '{16'h1000, 16'h2000, 16'h3000, 16'h4000, 16'h5000};

  initial begin
    idle_inputs();
    @(negedge clk);

    // reset then idle
    cyc(1, 0, 0, 16'h0, 0, 16'h0, 0, 0);
    check("rst_pc_a", pc, 32'h0);
    cyc(1, 0, 0, 16'h0, 0, 16'h0, 0, 0);
    check("rst_pc_b", pc, 32'h0);
    check("rst_empty", ras_empty, 1);
    check("rst_full", ras_full, 0);
    check("rst_err", ras_err, 0);
    for (int i = 1; i <= 3; i++) begin
      seq_cyc();
      check("idle_pc", pc, 32'(i));
    end
    check("idle_empty", ras_empty, 1);
    check("idle_err", ras_err, 0);

    // branch and wrap
    jmp_cyc(16'h0010);
    check("jmp_pc", pc, 32'h0010);
    cyc(0, 0, 1, 16'hFFF0, 0, 16'h0, 0, 0);
    check("br_neg", pc, 32'h0000);
    cyc(0, 0, 1, 16'h0005, 1, 16'hFFFF, 0, 0);
    check("jmp_over_br", pc, 32'hFFFF);
    seq_cyc();
    check("seq_wrap", pc, 32'h0000);
    cyc(0, 0, 1, 16'h0021, 0, 16'h0, 0, 0);
    check("br_pos", pc, 32'h0021);

    // single call / return
    jmp_cyc(16'h0100);
    call_cyc(16'h0200);
    check("call_pc", pc, 32'h0200);
    check("call_nonempty", ras_empty, 0);
    ret_cyc();
    check("ret_pc", pc, 32'h0101);
    check("ret_empty", ras_empty, 1);

    // five nested calls overflow a 4-deep stack
    for (int i = 0; i < 5; i++) begin
      call_cyc(tgts[i]);
      check("nest_pc", pc, 32'(tgts[i]));
      if (i == 3) begin
        check("full_at4", ras_full, 1);
        check("noerr_at4", ras_err, 0);
      end
    end
    check("ovf_full", ras_full, 1);
    check("ovf_err", ras_err, 1);
    for (int i = 0; i < 4; i++) begin
      ret_cyc();
      check("nest_ret", pc, 32'(exp_ret[i]));
      check("nest_notfull", ras_full, 0);
    end
    check("nest_empty", ras_empty, 1);
    ret_cyc();
    check("unf_pc", pc, 32'h1002);
    check("unf_empty", ras_empty, 1);
    check("unf_err", ras_err, 1);

    // stall, then ret and call in the same cycle
    call_cyc(16'h7000);
    check("c7_pc", pc, 32'h7000);
    cyc(0, 1, 1, 16'h0004, 1, 16'h9000, 1, 0);
    check("stall_pc", pc, 32'h7000);
    check("stall_empty", ras_empty, 0);
    cyc(0, 1, 0, 16'h0, 0, 16'h0, 0, 1);
    check("stall_ret_pc", pc, 32'h7000);
    call_cyc(16'h8000);
    check("c8_pc", pc, 32'h8000);
    cyc(0, 0, 0, 16'h0, 1, 16'hA000, 1, 1);
    check("retcall_pc", pc, 32'h7001);
    ret_cyc();
    check("retcall_nopush", pc, 32'h1003);
    check("retcall_empty", ras_empty, 1);

    // reset on a call edge
    call_cyc(16'hB000);
    check("cb_pc", pc, 32'hB000);
    cyc(1, 0, 0, 16'h0, 0, 16'hC000, 1, 0);
    check("rstcall_pc", pc, 32'h0);
    check("rstcall_empty", ras_empty, 1);
    check("rstcall_full", ras_full, 0);
    check("rstcall_err", ras_err, 0);
    ret_cyc();
    check("post_rst_ret_pc", pc, 32'h1);
    check("post_rst_ret_err", ras_err, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got running, expected finished");
    $fatal(1, "timeout");
  end

endmodule
